fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage with the IF/ID pipeline register. It sits directly upstream of hazard detection and consumes that block's stall, flush and halt outputs.
- Owns the PC, drives the instruction-memory address, and latches instruction + PC+4 into IF/ID.
- Runs a halt FSM that freezes fetch on HALT, waits for the back end to drain, then flags the core halted to the debug unit.

Parameters:
- PC_WIDTH, 32, width of PC and addresses
- RESET_PC, 32'h0000_0000, PC value after reset
- DRAIN_CYCLES, 3, cycles after HALT-in-ID until EX/MEM/WB are empty (range 1..15)
- NOP_INSTR, 32'h0000_0000, bubble written into IF/ID on flush or halt

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_stall  in  1  load-use stall from hazard detection
- i_flush  in  1  control-hazard flush from hazard detection
- i_redirect_pc  in  PC_WIDTH  target PC, valid when i_flush=1
- i_halt  in  1  HALT opcode currently in ID
- i_resume  in  1  debug request to leave HALTED
- i_resume_pc  in  PC_WIDTH  PC to restart from on resume
- o_imem_addr  out  PC_WIDTH  instruction memory address (= PC register)
- i_imem_data  in  32  instruction word, combinational read of o_imem_addr
- o_if_id_instr  out  32  IF/ID instruction
- o_if_id_pc_plus4  out  PC_WIDTH  IF/ID PC+4
- o_if_id_valid  out  1  IF/ID holds a real instruction
- o_halted  out  1  core halted and pipeline drained
- o_state  out  2  FSM state, for debug visibility

Behaviour:
- Reset (synchronous, dominates all inputs):
  - PC=RESET_PC, state=RUN.
  - o_if_id_instr=NOP_INSTR, o_if_id_pc_plus4=0, o_if_id_valid=0.
  - o_halted=0, drain counter=0.
- FSM encoding: RUN=0, DRAIN=1, HALTED=2; 3 is illegal and goes to RUN on the next edge.
- RUN, per-cycle priority: flush > halt > stall > advance.
  - Flush: PC<=i_redirect_pc; IF/ID<=NOP_INSTR, valid=0. i_halt in the same cycle is ignored because the HALT is on the wrong path. i_stall is ignored.
  - Halt (no flush): PC holds; IF/ID<=NOP_INSTR, valid=0; counter<=DRAIN_CYCLES-1; state<=DRAIN. Halt beats stall.
  - Stall: PC and IF/ID hold their values.
  - Advance: IF/ID<=(i_imem_data, PC+4, valid=1); PC<=PC+4.
- PC arithmetic: modulo 2^PC_WIDTH, so 32'hFFFF_FFFC+4 wraps to 0. Bits [1:0] are not checked.
- DRAIN:
  - PC frozen; IF/ID stays bubble; i_stall, i_flush and i_halt are ignored.
  - Counter decrements each cycle. When it reaches 0, state<=HALTED and o_halted<=1 on that same edge.
- HALTED:
  - PC frozen, IF/ID bubble, o_halted=1.
  - i_resume=1: PC<=i_resume_pc, state<=RUN, o_halted<=0. The first new instruction is latched into IF/ID one cycle later.
  - i_resume in RUN or DRAIN is ignored.
- Latency:
  - Instruction at address A appears on o_if_id_instr one cycle after o_imem_addr=A, with no stall.
  - From the cycle i_halt is sampled to o_halted=1: DRAIN_CYCLES cycles.
- o_imem_addr is the PC register output directly, so it is glitch-free and there is no combinational path from the i_* inputs to it.
- Reset asserted mid-DRAIN or in HALTED returns to RUN at RESET_PC on the next edge.

Test Plan:
- Reset, then free-run with imem[i]=i+1 -> PC 0,4,8,12; IF/ID receives instr 1,2,3 with pc_plus4 4,8,12, valid=1.
- i_stall=1 for 2 cycles while PC=8 -> PC stays 8, IF/ID holds (instr 2, 8) for both cycles; advance resumes after i_stall drops.
- i_flush=1, i_redirect_pc=0x40, with i_stall=1 and i_halt=1 all in the same cycle -> next PC=0x40, IF/ID=NOP with valid=0, state stays RUN; following fetch gives IF/ID pc_plus4=0x44.
- i_halt=1 with PC=0x20 and DRAIN_CYCLES=3 -> o_state goes 1 for 3 cycles; o_halted=1 exactly 3 cycles after i_halt; PC stays 0x20; valid=0 throughout; i_flush pulses during DRAIN have no effect.
- In HALTED, i_resume=1 with i_resume_pc=0x100 -> PC=0x100 next cycle, o_halted=0; IF/ID valid with pc_plus4=0x104 one cycle later.
- PC=32'hFFFF_FFFC advancing -> PC wraps to 0. Reset asserted during DRAIN -> PC=RESET_PC, state RUN, o_halted=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem, and fills the IF/ID register.
// A halt FSM freezes fetch, waits for the back end to drain, then reports halted.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal fetch; flush > halt > stall > advance
// DRAIN   | HALT seen in ID; PC frozen, bubbles issued, counting down
// HALTED  | pipeline empty, o_halted=1, waiting for debug resume
// (3)     | unreachable encoding, recovers to RUN on the next edge

module fetch_stage #(
   parameter int unsigned          PC_WIDTH     = 32,
   parameter logic [PC_WIDTH-1:0]  RESET_PC     = '0,
   parameter int unsigned          DRAIN_CYCLES = 3,
   parameter logic [31:0]          NOP_INSTR    = 32'h0000_0000
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_stall,
   input  logic                i_flush,
   input  logic [PC_WIDTH-1:0] i_redirect_pc,
   input  logic                i_halt,
   input  logic                i_resume,
   input  logic [PC_WIDTH-1:0] i_resume_pc,
   output logic [PC_WIDTH-1:0] o_imem_addr,
   input  logic [31:0]         i_imem_data,
   output logic [31:0]         o_if_id_instr,
   output logic [PC_WIDTH-1:0] o_if_id_pc_plus4,
   output logic                o_if_id_valid,
   output logic                o_halted,
   output logic [1:0]          o_state
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_HALTED  = 2'd2,
      ST_ILLEGAL = 2'd3
   } state_t;

   // Counter is loaded with N-1 so HALTED is reached exactly N edges after HALT.
   localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

   state_t              state_q;
   logic [PC_WIDTH-1:0] pc_q;
   logic [PC_WIDTH-1:0] pc_plus4_d;
   logic [31:0]         instr_q;
   logic [PC_WIDTH-1:0] pc_plus4_q;
   logic                valid_q;
   logic                halted_q;
   logic [3:0]          cnt_q;

   assign pc_plus4_d = pc_q + PC_WIDTH'(4);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= ST_RUN;
         pc_q       <= RESET_PC;
         instr_q    <= NOP_INSTR;
         pc_plus4_q <= '0;
         valid_q    <= 1'b0;
         halted_q   <= 1'b0;
         cnt_q      <= 4'd0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (i_flush) begin
                  // A HALT arriving with a flush is on the wrong path and is dropped.
                  pc_q    <= i_redirect_pc;
                  instr_q <= NOP_INSTR;
                  valid_q <= 1'b0;
               end else if (i_halt) begin
                  instr_q <= NOP_INSTR;
                  valid_q <= 1'b0;
                  cnt_q   <= DRAIN_INIT;
                  state_q <= ST_DRAIN;
               end else if (!i_stall) begin
                  instr_q    <= i_imem_data;
                  pc_plus4_q <= pc_plus4_d;
                  valid_q    <= 1'b1;
                  pc_q       <= pc_plus4_d;
               end
            end
            ST_DRAIN: begin
               if (cnt_q == 4'd0) begin
                  state_q  <= ST_HALTED;
                  halted_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_HALTED: begin
               if (i_resume) begin
                  pc_q     <= i_resume_pc;
                  state_q  <= ST_RUN;
                  halted_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= ST_RUN;
               instr_q  <= NOP_INSTR;
               valid_q  <= 1'b0;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   assign o_imem_addr      = pc_q;
   assign o_if_id_instr    = instr_q;
   assign o_if_id_pc_plus4 = pc_plus4_q;
   assign o_if_id_valid    = valid_q;
   assign o_halted         = halted_q;
   assign o_state          = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and random checks of fetch_stage against a cycle-level behavioural model.

module tb_fetch_stage;

   localparam int          DRAIN_N = 3;
   localparam logic [31:0] NOP     = 32'h0000_0000;
   localparam logic [31:0] RST_PC  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset, stall, flush, halt, resume;
   logic [31:0] redirect_pc, resume_pc;
   logic [31:0] imem_addr, imem_data;
   logic [31:0] if_id_instr, if_id_pc4;
   logic        if_id_valid, halted;
   logic [1:0]  state;

   int total = 0;
   int bad   = 0;

   // Model: mode 0=run 1=drain 2=halted; left = cycles until halted is reported.
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid, m_halted;
   int          m_mode, m_left;

   fetch_stage #(
      .PC_WIDTH(32), .RESET_PC(RST_PC), .DRAIN_CYCLES(DRAIN_N), .NOP_INSTR(NOP)
   ) dut (
      .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_flush(flush),
      .i_redirect_pc(redirect_pc), .i_halt(halt), .i_resume(resume),
      .i_resume_pc(resume_pc), .o_imem_addr(imem_addr), .i_imem_data(imem_data),
      .o_if_id_instr(if_id_instr), .o_if_id_pc_plus4(if_id_pc4),
      .o_if_id_valid(if_id_valid), .o_halted(halted), .o_state(state)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a >> 2) + 32'd1;
   endfunction

   assign imem_data = mem_word(imem_addr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      if (reset) begin
         m_pc = RST_PC; m_mode = 0; m_instr = NOP; m_pc4 = '0;
         m_valid = 1'b0; m_halted = 1'b0; m_left = 0;
      end else if (m_mode == 0) begin
         if (flush) begin
            m_pc = redirect_pc; m_instr = NOP; m_valid = 1'b0;
         end else if (halt) begin
            m_instr = NOP; m_valid = 1'b0; m_mode = 1; m_left = DRAIN_N;
         end else if (!stall) begin
            m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4;
            m_valid = 1'b1; m_pc = m_pc + 32'd4;
         end
      end else if (m_mode == 1) begin
         m_left--;
         if (m_left == 0) begin
            m_mode = 2; m_halted = 1'b1;
         end
      end else if (resume) begin
         m_pc = resume_pc; m_mode = 0; m_halted = 1'b0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("pc",     imem_addr,   m_pc);
      check("instr",  if_id_instr, m_instr);
      check("pc4",    if_id_pc4,   m_pc4);
      check("valid",  {31'd0, if_id_valid}, {31'd0, m_valid});
      check("halted", {31'd0, halted},      {31'd0, m_halted});
      check("state",  {30'd0, state},       32'(m_mode));
   endtask

   task automatic idle();
      reset = 0; stall = 0; flush = 0; halt = 0; resume = 0;
   endtask

   initial begin
      idle();
      redirect_pc = '0; resume_pc = '0;
      m_pc = '0; m_instr = '0; m_pc4 = '0; m_valid = 0; m_halted = 0; m_mode = 0; m_left = 0;

      // reset state
      reset = 1; step(); step();
      check("rst_pc", imem_addr, 32'h0);
      idle();

      // free run: PC 0 -> 4 -> 8
      step(); step();
      check("run_instr2", if_id_instr, 32'd2);
      check("run_pc4_8", if_id_pc4, 32'd8);

      // two stall cycles at PC=8
      stall = 1; step(); step();
      check("stall_pc", imem_addr, 32'd8);
      check("stall_instr", if_id_instr, 32'd2);
      stall = 0; step();
      check("after_stall_instr", if_id_instr, 32'd3);

      // flush beats halt and stall
      flush = 1; stall = 1; halt = 1; redirect_pc = 32'h40; step();
      check("flush_pc", imem_addr, 32'h40);
      check("flush_state", {30'd0, state}, 32'd0);
      idle(); step();
      check("flush_pc4", if_id_pc4, 32'h44);

      // halt at PC=0x20 with flush pulses during drain
      flush = 1; redirect_pc = 32'h20; step(); idle();
      halt = 1; step(); halt = 0;
      flush = 1; redirect_pc = 32'h80; step();
      flush = 0; step();
      flush = 1; step(); idle();
      check("halt_done", {31'd0, halted}, 32'd1);
      check("halt_pc", imem_addr, 32'h20);
      step();

      // resume from HALTED
      resume = 1; resume_pc = 32'h100; step(); idle();
      check("resume_pc", imem_addr, 32'h100);
      step();
      check("resume_pc4", if_id_pc4, 32'h104);

      // PC wrap
      flush = 1; redirect_pc = 32'hFFFF_FFFC; step(); idle(); step();
      check("wrap_pc", imem_addr, 32'h0);

      // reset in the middle of DRAIN
      halt = 1; step(); idle(); step();
      reset = 1; step(); idle();
      check("rst_drain_state", {30'd0, state}, 32'd0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         reset  = ($urandom_range(99, 0) < 1);
         flush  = ($urandom_range(99, 0) < 10);
         halt   = ($urandom_range(99, 0) < 8);
         stall  = ($urandom_range(99, 0) < 20);
         resume = ($urandom_range(99, 0) < 30);
         redirect_pc = $urandom() & 32'hFFFF_FFFC;
         resume_pc   = $urandom();
         step();
      end
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
